// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_layer_sequencer
//  Description : Runs one convolution layer row by row across the parallel
//                edge-detection engines. For each output row it pulses the
//                shared engine start, collects every engine's done, snapshots
//                all results into a shadow buffer and streams them to the
//                feature-map write port with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_ENGINES     = 4,
    parameter int OUTS_PER_ENGINE = 24,
    parameter int NUM_ROWS        = 24,
    parameter int ADDR_WIDTH      = 12,
    parameter int BASE_ADDR       = 0,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              layer_start,
    output logic                                              layer_busy,
    output logic                                              layer_done,
    output logic                                              layer_err,
    output logic                                              eng_start,
    input  logic [NUM_ENGINES-1:0]                            eng_done,
    input  logic [NUM_ENGINES*OUTS_PER_ENGINE*DATA_WIDTH-1:0] eng_data,
    output logic                                              wr_valid,
    input  logic                                              wr_ready,
    output logic [ADDR_WIDTH-1:0]                             wr_addr,
    output logic [DATA_WIDTH-1:0]                             wr_data
);

    // ------------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------------
    localparam int c_WORDS = NUM_ENGINES * OUTS_PER_ENGINE;
    localparam int c_K_W   = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int c_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_K_W-1:0]      c_K_LAST     = c_K_W'(c_WORDS - 1);
    localparam logic [c_ROW_W-1:0]    c_ROW_LAST   = c_ROW_W'(NUM_ROWS - 1);
    localparam logic [c_TO_W-1:0]     c_TO_LAST    = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_ROW_STRIDE = ADDR_WIDTH'(c_WORDS);

    // State encoding
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_START   = 3'd1;
    localparam logic [2:0] c_ST_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_CAPTURE = 3'd3;
    localparam logic [2:0] c_ST_DRAIN   = 3'd4;
    localparam logic [2:0] c_ST_NEXT    = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]             r_state;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_K_W-1:0]       r_k;
    logic [c_TO_W-1:0]      r_to_cnt;
    logic [NUM_ENGINES-1:0] r_done_seen;
    logic [DATA_WIDTH-1:0]  r_shadow [c_WORDS];

    logic                   r_layer_busy;
    logic                   r_layer_done;
    logic                   r_layer_err;
    logic                   r_eng_start;
    logic                   r_wr_valid;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0]  r_wr_data;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  w_words [c_WORDS];
    logic                   w_all_done;
    logic [c_K_W-1:0]       w_k_next;
    logic [ADDR_WIDTH-1:0]  w_row_base;

    // Split the flat engine bus into individual result words (word k = engine*OUTS + index)
    generate
        for (genvar gi = 0; gi < c_WORDS; gi++) begin : g_unpack
            assign w_words[gi] = eng_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // A done seen in an earlier WAIT cycle counts just like one arriving now
    assign w_all_done = &(r_done_seen | eng_done);
    assign w_k_next   = r_k + c_K_W'(1);
    // Address of word 0 of the current row; wraps naturally at ADDR_WIDTH
    assign w_row_base = c_BASE + (ADDR_WIDTH'(r_row) * c_ROW_STRIDE);

    // ------------------------------------------------------------------------
    // Shadow buffer: loaded only in CAPTURE so engines are free to change
    // their outputs while the row is being drained.
    // ------------------------------------------------------------------------
    // Snapshot all engine results once every engine has reported done
    always_ff @(posedge clk) begin
        if (r_state == c_ST_CAPTURE) begin
            for (int i = 0; i < c_WORDS; i++) begin
                r_shadow[i] <= w_words[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Layer sequencing FSM with registered outputs
    // ------------------------------------------------------------------------
    // Row loop: start engines, collect done, capture, drain, advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_row        <= '0;
            r_k          <= '0;
            r_to_cnt     <= '0;
            r_done_seen  <= '0;
            r_layer_busy <= 1'b0;
            r_layer_done <= 1'b0;
            r_layer_err  <= 1'b0;
            r_eng_start  <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (layer_start) begin
                        r_row        <= '0;
                        r_done_seen  <= '0;
                        r_layer_err  <= 1'b0;
                        r_layer_busy <= 1'b1;
                        r_eng_start  <= 1'b1;
                        r_state      <= c_ST_START;
                    end
                end

                c_ST_START: begin
                    // eng_start was raised on entry, so it lasts exactly this cycle
                    r_eng_start <= 1'b0;
                    r_done_seen <= '0;
                    r_to_cnt    <= '0;
                    r_state     <= c_ST_WAIT;
                end

                c_ST_WAIT: begin
                    r_done_seen <= r_done_seen | eng_done;
                    if (w_all_done) begin
                        r_state <= c_ST_CAPTURE;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        // Give up on this layer; no writes are issued for the row
                        r_layer_err  <= 1'b1;
                        r_layer_done <= 1'b1;
                        r_state      <= c_ST_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end

                c_ST_CAPTURE: begin
                    // Word 0 comes straight from the bus being captured this cycle
                    r_k        <= '0;
                    r_wr_addr  <= w_row_base;
                    r_wr_data  <= w_words[0];
                    r_wr_valid <= 1'b1;
                    r_state    <= c_ST_DRAIN;
                end

                c_ST_DRAIN: begin
                    // Without a handshake the presented word simply holds
                    if (wr_ready) begin
                        if (r_k == c_K_LAST) begin
                            r_wr_valid <= 1'b0;
                            r_state    <= c_ST_NEXT;
                        end else begin
                            r_k       <= w_k_next;
                            r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                            r_wr_data <= r_shadow[w_k_next];
                        end
                    end
                end

                c_ST_NEXT: begin
                    if (r_row == c_ROW_LAST) begin
                        r_layer_done <= 1'b1;
                        r_state      <= c_ST_DONE;
                    end else begin
                        r_row       <= r_row + c_ROW_W'(1);
                        r_eng_start <= 1'b1;
                        r_state     <= c_ST_START;
                    end
                end

                c_ST_DONE: begin
                    // layer_start seen here is dropped; IDLE accepts the next one
                    r_layer_done <= 1'b0;
                    r_layer_busy <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end

                default: begin
                    r_eng_start  <= 1'b0;
                    r_wr_valid   <= 1'b0;
                    r_layer_done <= 1'b0;
                    r_layer_busy <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign layer_busy = r_layer_busy;
    assign layer_done = r_layer_done;
    assign layer_err  = r_layer_err;
    assign eng_start  = r_eng_start;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_layer_sequencer
//  Description : Scoreboard bench for conv_layer_sequencer. An engine model
//                answers each eng_start with random results and a done
//                schedule and queues the writes the layer must produce; an
//                independent monitor pops and compares every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

    localparam int DW    = 16;
    localparam int NE    = 4;
    localparam int OPE   = 24;
    localparam int NR    = 24;
    localparam int AW    = 12;
    localparam int TO    = 16;
    localparam int WORDS = NE * OPE;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  main_start;
    logic                  spam_start;
    logic                  layer_start;
    logic                  layer_busy;
    logic                  layer_done;
    logic                  layer_err;
    logic                  eng_start;
    logic [NE-1:0]         eng_done;
    logic [NE*OPE*DW-1:0]  eng_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;

    assign layer_start = main_start | spam_start;

    conv_layer_sequencer #(
        .DATA_WIDTH      (DW),
        .NUM_ENGINES     (NE),
        .OUTS_PER_ENGINE (OPE),
        .NUM_ROWS        (NR),
        .ADDR_WIDTH      (AW),
        .BASE_ADDR       (0),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .layer_start (layer_start),
        .layer_busy  (layer_busy),
        .layer_done  (layer_done),
        .layer_err   (layer_err),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_data    (eng_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_starts = 0;
    int n_dones  = 0;
    int n_writes = 0;

    // stimulus configuration shared with the engine model and ready driver
    int   sched_mode = 0;   // 0: all done at WAIT 5, 1: staggered, 2: random
    int   ready_mode = 0;   // 0: always, 1: 1,0,0,1 pattern, 2: random
    int   to_row     = -1;  // row whose engine 2 never finishes
    int   rsp_row    = 0;
    logic spam_en    = 1'b0;
    int   ph         = 0;

    // monitor state
    logic          stall = 1'b0;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;

    // per-layer snapshots
    int s0, w0, d0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NE*OPE*DW-1:0] rand_vec();
        logic [NE*OPE*DW-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Engine model: one call per observed eng_start (called at its negedge)
    // ------------------------------------------------------------------------
    task automatic run_row();
        int                   done_at [NE];
        int                   last;
        int                   row;
        bit                   tmo;
        logic [NE*OPE*DW-1:0] vec;
        logic [NE-1:0]        bits;
        wr_t                  e;

        row = rsp_row;
        rsp_row++;
        tmo = (row == to_row);
        for (int i = 0; i < NE; i++) begin
            case (sched_mode)
                0:       done_at[i] = 5;
                2:       done_at[i] = $urandom_range(1, 12);
                default: done_at[i] = 0;
            endcase
        end
        if (sched_mode == 1) begin
            // engine 3 at WAIT 2, engine 0 at 4, engine 2 at 7, engine 1 at 9
            done_at[0] = 4; done_at[1] = 9; done_at[2] = 7; done_at[3] = 2;
        end
        if (tmo) done_at[2] = 0;

        vec = rand_vec();
        eng_data = vec;
        if (!tmo) begin
            for (int k = 0; k < WORDS; k++) begin
                e.addr = AW'(row * WORDS + k);
                e.data = vec[k*DW +: DW];
                exp_q.push_back(e);
            end
        end

        last = 0;
        for (int i = 0; i < NE; i++) if (done_at[i] > last) last = done_at[i];
        if (tmo) last = TO;

        for (int j = 1; j <= last; j++) begin
            @(posedge clk); #1;
            bits = '0;
            for (int i = 0; i < NE; i++) if (done_at[i] == j) bits[i] = 1'b1;
            eng_done = bits;
        end

        if (tmo) begin
            @(negedge clk);
            check("timeout_not_early", layer_done, 1'b0);
            @(posedge clk); #1;
            eng_done = '0;
            @(negedge clk);
            check("timeout_done", layer_done, 1'b1);
            check("timeout_err", layer_err, 1'b1);
            return;
        end

        @(posedge clk); #1;
        eng_done = '0;
        @(negedge clk);
        check("no_early_valid", wr_valid, 1'b0);
        @(posedge clk); #1;
        // results are already captured: scramble them and inject stray dones
        eng_data = rand_vec();
        eng_done = NE'($urandom);
        @(negedge clk);
        check("first_valid_latency", wr_valid, 1'b1);
        @(posedge clk); #1;
        eng_done = '0;
    endtask

    initial begin
        eng_done = '0;
        eng_data = rand_vec();
        forever begin
            @(negedge clk);
            if (!rst && eng_start) run_row();
        end
    end

    // ------------------------------------------------------------------------
    // Sink ready driver and busy-time layer_start noise
    // ------------------------------------------------------------------------
    initial begin
        wr_ready   = 1'b0;
        spam_start = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: wr_ready = ($urandom_range(0, 3) != 0);
            endcase
            ph++;
            spam_start = spam_en && layer_busy && !layer_done && ($urandom_range(0, 7) == 0);
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: pops the scoreboard on every handshake, checks stall stability
    // ------------------------------------------------------------------------
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            if (eng_start)  n_starts++;
            if (layer_done) n_dones++;
            if (stall) check("stall_hold", {wr_valid, wr_addr, wr_data}, {1'b1, st_addr, st_data});
            stall = 1'b0;
            if (wr_valid) begin
                if (wr_ready) begin
                    n_writes++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                    end
                end else begin
                    stall   = 1'b1;
                    st_addr = wr_addr;
                    st_data = wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequence helpers (all entered and left at a negedge)
    // ------------------------------------------------------------------------
    task automatic snap();
        s0 = n_starts; w0 = n_writes; d0 = n_dones;
    endtask

    task automatic launch();
        main_start = 1'b1;
        @(posedge clk); #1;
        main_start = 1'b0;
        @(negedge clk);
        check("start_eng_start", eng_start, 1'b1);
        check("start_busy", layer_busy, 1'b1);
        check("start_err_clear", layer_err, 1'b0);
    endtask

    task automatic wait_done(input int budget, input string name);
        int t = 0;
        while (!layer_done && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (!layer_done) begin
            n_bad++;
            $display("FAIL %s_done_timeout: no layer_done within %0d cycles, required a pulse", name, budget);
        end
    endtask

    task automatic finish_layer(input string name, input int exp_starts, input int exp_writes,
                                input logic exp_err, input bit chain);
        wait_done(8000, name);
        spam_en = 1'b0;
        check("done_err", layer_err, exp_err);
        if (chain) main_start = 1'b1;
        @(negedge clk);
        check("done_pulse_width", layer_done, 1'b0);
        check("busy_drop", layer_busy, 1'b0);
        check("start_ignored_in_done", eng_start, 1'b0);
        check("layer_starts", n_starts - s0, exp_starts);
        check("layer_writes", n_writes - w0, exp_writes);
        check("layer_done_count", n_dones - d0, 1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int t;
        rst        = 1'b1;
        main_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", layer_busy, 1'b0);
        check("rst_done", layer_done, 1'b0);
        check("rst_err", layer_err, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A: all engines done together at WAIT 5, sink always ready
        sched_mode = 0; ready_mode = 0; to_row = -1; rsp_row = 0;
        snap();
        launch();
        finish_layer("A", NR, NR * WORDS, 1'b0, 1'b0);
        @(negedge clk);

        // B: staggered done, 1,0,0,1 backpressure, layer_start noise while busy
        sched_mode = 1; ready_mode = 1; rsp_row = 0; ph = 0; spam_en = 1'b1;
        snap();
        launch();
        finish_layer("B", NR, NR * WORDS, 1'b0, 1'b1);

        // C: started in the first IDLE cycle after B's DONE; random everything
        sched_mode = 2; ready_mode = 2; rsp_row = 0; spam_en = 1'b1;
        snap();
        @(posedge clk); #1;
        main_start = 1'b0;
        @(negedge clk);
        check("chain_eng_start", eng_start, 1'b1);
        check("chain_busy", layer_busy, 1'b1);
        finish_layer("C", NR, NR * WORDS, 1'b0, 1'b0);
        @(negedge clk);

        // D: engine 2 never finishes on row 2
        sched_mode = 2; ready_mode = 2; to_row = 2; rsp_row = 0;
        snap();
        launch();
        finish_layer("D", 3, 2 * WORDS, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("err_sticky", layer_err, 1'b1);
        to_row = -1;

        // E: reset while row 3 word 40 is presented
        sched_mode = 2; ready_mode = 0; rsp_row = 0;
        snap();
        launch();
        t = 0;
        while (!(wr_valid && wr_addr == AW'(3 * WORDS + 40)) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("reach_row3_k40", {wr_valid, wr_addr}, {1'b1, AW'(3 * WORDS + 40)});
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", layer_busy, 1'b0);
        check("mid_rst_done", layer_done, 1'b0);
        check("mid_rst_err", layer_err, 1'b0);
        check("mid_rst_eng_start", eng_start, 1'b0);
        check("mid_rst_wr_valid", wr_valid, 1'b0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        rst = 1'b0;
        exp_q.delete();
        d0 = n_dones;
        repeat (10) @(negedge clk);
        check("abandoned_no_done", n_dones - d0, 0);
        check("abandoned_idle", {layer_busy, wr_valid, eng_start}, 3'b000);

        // F: fresh layer after reset restarts at address 0
        sched_mode = 0; ready_mode = 2; rsp_row = 0;
        snap();
        launch();
        finish_layer("F", NR, NR * WORDS, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
